// File: rtl/attrib_block_seq.sv
// Attribute-block sequencer: tags each word of an attribute block with its
// role, position and latched block fields behind one registered output stage.

package pkg_en;
  localparam int WIDTH_DATA            = 32;
  localparam int WIDTH_LENGTH          = 8;
  localparam int POSIT_ATTRIB_MODE_LSB = 0;
  localparam int POSIT_ATTRIB_MODE_MSB = 1;
  localparam int POSIT_ATTRIB_SHARED   = 2;
  localparam int POSIT_ATTRIB_NONZERO  = 3;
  localparam int POSIT_ATTRIB_TERM     = 4;
  localparam int POSIT_ATTRIB_MYATTRIB = 5;
  localparam int POSIT_ATTRIB_PULL     = 6;
endpackage

module attrib_block_seq #(
  parameter int WIDTH_DATA   = pkg_en::WIDTH_DATA,
  parameter int WIDTH_LENGTH = pkg_en::WIDTH_LENGTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    I_Valid,
  input  logic [WIDTH_DATA-1:0]   I_Data,
  output logic                    O_Nack,
  input  logic                    I_Nack,
  output logic                    O_Valid,
  output logic [WIDTH_DATA-1:0]   O_Data,
  output logic [1:0]              O_Kind,
  output logic [1:0]              O_Mode,
  output logic [4:0]              O_Flags,
  output logic [WIDTH_DATA-1:0]   O_Shared,
  output logic [WIDTH_LENGTH-1:0] O_Remain,
  output logic                    O_Last,
  output logic                    O_Term
);
  import pkg_en::*;

  typedef enum logic [1:0] {ATTR, SHRD, BODY} state_t;

  localparam logic [1:0] KIND_ATTR = 2'd0;
  localparam logic [1:0] KIND_SHRD = 2'd1;
  localparam logic [1:0] KIND_BODY = 2'd2;
  // Term position inside the packed {Pull, MyAttrib, Term, NonZero, Shared}
  localparam int FLAG_TERM = 2;

  state_t                  state, nxt_state;
  logic [WIDTH_LENGTH-1:0] cnt, nxt_cnt;
  logic [1:0]              kind_n, mode_n;
  logic [4:0]              flags_n;
  logic [WIDTH_DATA-1:0]   shared_n;
  logic                    last_n, term_n;
  logic                    advance;
  logic [WIDTH_LENGTH-1:0] len_in;
  logic [4:0]              flags_in;

  // Output register may be overwritten when empty or draining this cycle
  assign advance = !O_Valid || !I_Nack;
  assign O_Nack  = O_Valid && I_Nack;

  assign len_in   = I_Data[WIDTH_LENGTH+7:8];
  assign flags_in = {I_Data[POSIT_ATTRIB_PULL], I_Data[POSIT_ATTRIB_MYATTRIB],
                     I_Data[POSIT_ATTRIB_TERM], I_Data[POSIT_ATTRIB_NONZERO],
                     I_Data[POSIT_ATTRIB_SHARED]};

  // Next-state and tagging of the word currently presented on the input
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    kind_n    = KIND_ATTR;
    last_n    = 1'b0;
    mode_n    = O_Mode;
    flags_n   = O_Flags;
    shared_n  = O_Shared;
    case (state)
      ATTR: begin
        mode_n   = I_Data[POSIT_ATTRIB_MODE_MSB:POSIT_ATTRIB_MODE_LSB];
        flags_n  = flags_in;
        shared_n = '0;
        nxt_cnt  = len_in;
        if (I_Data[POSIT_ATTRIB_SHARED]) nxt_state = SHRD;
        else if (len_in != '0)           nxt_state = BODY;
        else                             last_n    = 1'b1;
      end
      SHRD: begin
        kind_n   = KIND_SHRD;
        shared_n = I_Data;
        if (cnt != '0) nxt_state = BODY;
        else begin
          nxt_state = ATTR;
          last_n    = 1'b1;
        end
      end
      BODY: begin
        kind_n  = KIND_BODY;
        // cnt >= 1 whenever we are in BODY, so this never wraps
        nxt_cnt = cnt - WIDTH_LENGTH'(1);
        if (cnt == WIDTH_LENGTH'(1)) begin
          nxt_state = ATTR;
          last_n    = 1'b1;
        end
      end
      default: nxt_state = ATTR;
    endcase
    term_n = last_n && flags_n[FLAG_TERM];
  end

  // State, counter and output register; everything holds while stalled
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ATTR;
      cnt      <= '0;
      O_Valid  <= 1'b0;
      O_Data   <= '0;
      O_Kind   <= '0;
      O_Mode   <= '0;
      O_Flags  <= '0;
      O_Shared <= '0;
      O_Remain <= '0;
      O_Last   <= 1'b0;
      O_Term   <= 1'b0;
    end else if (advance) begin
      O_Valid <= I_Valid;
      if (I_Valid) begin
        state    <= nxt_state;
        cnt      <= nxt_cnt;
        O_Data   <= I_Data;
        O_Kind   <= kind_n;
        O_Mode   <= mode_n;
        O_Flags  <= flags_n;
        O_Shared <= shared_n;
        O_Remain <= nxt_cnt;
        O_Last   <= last_n;
        O_Term   <= term_n;
      end
    end
  end
endmodule

// File: tb/tb_attrib_block_seq.sv
// Scoreboard bench for attrib_block_seq: a spec-level model pushes expected
// tags on acceptance; a negedge monitor pops them as output words drain.

module tb_attrib_block_seq;
  localparam int WD = 32;
  localparam int WL = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          I_Valid = 1'b0;
  logic [WD-1:0] I_Data = '0;
  logic          I_Nack = 1'b0;
  logic          O_Nack, O_Valid, O_Last, O_Term;
  logic [WD-1:0] O_Data, O_Shared;
  logic [1:0]    O_Kind, O_Mode;
  logic [4:0]    O_Flags;
  logic [WL-1:0] O_Remain;

  attrib_block_seq dut (
    .clock(clock), .reset(reset), .I_Valid(I_Valid), .I_Data(I_Data),
    .O_Nack(O_Nack), .I_Nack(I_Nack), .O_Valid(O_Valid), .O_Data(O_Data),
    .O_Kind(O_Kind), .O_Mode(O_Mode), .O_Flags(O_Flags), .O_Shared(O_Shared),
    .O_Remain(O_Remain), .O_Last(O_Last), .O_Term(O_Term)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [WD-1:0] data;
    logic [1:0]    kind;
    logic [1:0]    mode;
    logic [4:0]    flags;
    logic [WD-1:0] shared;
    logic [WL-1:0] remain;
    logic          last;
    logic          term;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state: 0 attribute, 1 shared, 2 body
  int            m_st = 0;
  logic [WL-1:0] m_cnt = '0;
  logic [1:0]    m_mode = '0;
  logic [4:0]    m_flags = '0;
  logic [WD-1:0] m_shared = '0;

  function automatic logic [WD-1:0] attr(input int mode, input int len,
                                         input bit sh, input bit term);
    logic [WD-1:0] d;
    d = '0;
    d[1:0]  = mode[1:0];
    d[2]    = sh;
    d[3]    = (len != 0);
    d[4]    = term;
    d[15:8] = len[7:0];
    return d;
  endfunction

  function automatic exp_t model_step(input logic [WD-1:0] d);
    exp_t e;
    e = '0;
    e.data = d;
    if (m_st == 0) begin
      m_mode   = d[1:0];
      m_flags  = {d[6], d[5], d[4], d[3], d[2]};
      m_shared = '0;
      m_cnt    = d[15:8];
      e.kind   = 2'd0;
      if (d[2]) m_st = 1;
      else if (m_cnt != 0) m_st = 2;
      else e.last = 1'b1;
    end else if (m_st == 1) begin
      m_shared = d;
      e.kind   = 2'd1;
      if (m_cnt != 0) m_st = 2;
      else begin m_st = 0; e.last = 1'b1; end
    end else begin
      e.kind = 2'd2;
      if (m_cnt == 1) begin m_st = 0; e.last = 1'b1; end
      m_cnt = m_cnt - 1;
    end
    e.mode   = m_mode;
    e.flags  = m_flags;
    e.shared = m_shared;
    e.remain = m_cnt;
    e.term   = e.last && m_flags[2];
    return e;
  endfunction

  // Scoreboard monitor: a word leaves the register when O_Valid && !I_Nack
  always @(negedge clock) begin
    if (!reset && O_Valid && !I_Nack) begin
      exp_t e;
      n_cmp++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got data=%h kind=%0d with no word pending", O_Data, O_Kind);
      end else begin
        e = sbq.pop_front();
        if ({O_Data, O_Kind, O_Mode, O_Flags, O_Shared, O_Remain, O_Last, O_Term} !== e) begin
          n_err++;
          $display("FAIL sb_word: got d=%h k=%0d m=%0d f=%b s=%h r=%0d l=%b t=%b want d=%h k=%0d m=%0d f=%b s=%h r=%0d l=%b t=%b",
                   O_Data, O_Kind, O_Mode, O_Flags, O_Shared, O_Remain, O_Last, O_Term,
                   e.data, e.kind, e.mode, e.flags, e.shared, e.remain, e.last, e.term);
        end
      end
    end
  end

  // Present one word; returns #1 after the edge that accepted it
  task automatic send(input logic [WD-1:0] d);
    int waited;
    I_Valid = 1'b1;
    I_Data  = d;
    waited  = 0;
    @(negedge clock);
    while (O_Nack && waited < 50) begin
      waited++;
      @(negedge clock);
    end
    if (O_Nack) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: O_Nack=%b after %0d cycles, want 0", O_Nack, waited);
    end
    sbq.push_back(model_step(d));
    @(posedge clock); #1;
  endtask

  task automatic idle_drain();
    int waited;
    I_Valid = 1'b0;
    waited  = 0;
    while (sbq.size() != 0 && waited < 40) begin
      @(posedge clock); #1;
      waited++;
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d words still pending, want 0", sbq.size());
    end
    sbq.delete();
  endtask

  task automatic check_reset_values(input string tag);
    n_cmp++;
    if ({O_Valid, O_Data, O_Kind, O_Mode, O_Flags, O_Shared, O_Remain, O_Last, O_Term, O_Nack} !== '0) begin
      n_err++;
      $display("FAIL %s: v=%b d=%h k=%0d m=%0d f=%b s=%h r=%0d l=%b t=%b nack=%b, want all zero",
               tag, O_Valid, O_Data, O_Kind, O_Mode, O_Flags, O_Shared, O_Remain, O_Last, O_Term, O_Nack);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    I_Valid = 1'b1;
    I_Data  = 32'hFFFF_FFFF;
    I_Nack  = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_reset_values("reset_state");
    I_Valid = 1'b0;
    I_Nack  = 1'b0;
    reset   = 1'b0;
    @(posedge clock); #1;
    check_reset_values("after_reset");
  endtask

  task automatic test_plain();
    logic [1:0]    k_tab [4] = '{2'd0, 2'd2, 2'd2, 2'd2};
    logic [WL-1:0] r_tab [4] = '{8'd3, 8'd2, 8'd1, 8'd0};
    logic          l_tab [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      send(i == 0 ? attr(0, 3, 0, 0) : 32'h1000 + i);
      n_cmp++;
      if ({O_Valid, O_Kind, O_Remain, O_Last} !== {1'b1, k_tab[i], r_tab[i], l_tab[i]}) begin
        n_err++;
        $display("FAIL plain_w%0d: v=%b k=%0d r=%0d l=%b want v=1 k=%0d r=%0d l=%b",
                 i, O_Valid, O_Kind, O_Remain, O_Last, k_tab[i], r_tab[i], l_tab[i]);
      end
    end
    idle_drain();
  endtask

  task automatic test_shared();
    logic [1:0] k_tab [4] = '{2'd0, 2'd1, 2'd2, 2'd2};
    logic [WD-1:0] w [4];
    w[0] = attr(2, 2, 1, 0); w[1] = 32'hA5; w[2] = 32'h2001; w[3] = 32'h2002;
    for (int i = 0; i < 4; i++) begin
      send(w[i]);
      n_cmp++;
      if ({O_Kind, O_Shared, O_Last} !== {k_tab[i], (i == 0) ? 32'h0 : 32'hA5, (i == 3) ? 1'b1 : 1'b0}) begin
        n_err++;
        $display("FAIL shared_w%0d: k=%0d s=%h l=%b want k=%0d s=%h l=%b", i, O_Kind, O_Shared, O_Last,
                 k_tab[i], (i == 0) ? 32'h0 : 32'hA5, (i == 3));
      end
    end
    idle_drain();
  endtask

  task automatic test_zero_len();
    send(attr(1, 0, 0, 1));
    n_cmp++;
    if ({O_Kind, O_Last, O_Term, O_Remain} !== {2'd0, 1'b1, 1'b1, 8'd0}) begin
      n_err++;
      $display("FAIL zero_term: k=%0d l=%b t=%b r=%0d want k=0 l=1 t=1 r=0", O_Kind, O_Last, O_Term, O_Remain);
    end
    send(attr(2, 0, 1, 0));
    n_cmp++;
    if ({O_Kind, O_Mode, O_Last} !== {2'd0, 2'd2, 1'b0}) begin
      n_err++;
      $display("FAIL zero_next_attr: k=%0d m=%0d l=%b want k=0 m=2 l=0", O_Kind, O_Mode, O_Last);
    end
    send(32'h5A5A);
    n_cmp++;
    if ({O_Kind, O_Last, O_Term, O_Shared} !== {2'd1, 1'b1, 1'b0, 32'h5A5A}) begin
      n_err++;
      $display("FAIL zero_shared_last: k=%0d l=%b t=%b s=%h want k=1 l=1 t=0 s=5a5a", O_Kind, O_Last, O_Term, O_Shared);
    end
    idle_drain();
  endtask

  task automatic test_backpressure();
    logic [WD+WD+WL+13:0] snap;
    send(attr(0, 4, 0, 1));
    send(32'h3000);
    I_Valid = 1'b1;
    I_Data  = 32'h3001;
    I_Nack  = 1'b1;
    snap = {O_Valid, O_Data, O_Kind, O_Mode, O_Flags, O_Shared, O_Remain, O_Last, O_Term};
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_cmp++;
      if (O_Nack !== 1'b1 || {O_Valid, O_Data, O_Kind, O_Mode, O_Flags, O_Shared, O_Remain, O_Last, O_Term} !== snap) begin
        n_err++;
        $display("FAIL stall_c%0d: nack=%b d=%h r=%0d want nack=1 d=3000 r=3", c, O_Nack, O_Data, O_Remain);
      end
      @(posedge clock); #1;
    end
    I_Nack = 1'b0;
    send(32'h3001);
    send(32'h3002);
    send(32'h3003);
    n_cmp++;
    if ({O_Data, O_Last, O_Term} !== {32'h3003, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL stall_resume: d=%h l=%b t=%b want d=3003 l=1 t=1", O_Data, O_Last, O_Term);
    end
    idle_drain();
  endtask

  task automatic test_back_to_back();
    send(attr(1, 1, 0, 0));
    send(32'h4001);
    n_cmp++;
    if ({O_Valid, O_Kind, O_Mode} !== {1'b1, 2'd2, 2'd1}) begin
      n_err++;
      $display("FAIL b2b_body1: v=%b k=%0d m=%0d want v=1 k=2 m=1", O_Valid, O_Kind, O_Mode);
    end
    send(attr(3, 1, 0, 0));
    n_cmp++;
    if ({O_Valid, O_Kind, O_Mode} !== {1'b1, 2'd0, 2'd3}) begin
      n_err++;
      $display("FAIL b2b_attr2: v=%b k=%0d m=%0d want v=1 k=0 m=3", O_Valid, O_Kind, O_Mode);
    end
    send(32'h4002);
    n_cmp++;
    if ({O_Valid, O_Mode, O_Last} !== {1'b1, 2'd3, 1'b1}) begin
      n_err++;
      $display("FAIL b2b_body2: v=%b m=%0d l=%b want v=1 m=3 l=1", O_Valid, O_Mode, O_Last);
    end
    idle_drain();
    n_cmp++;
    if (O_Valid !== 1'b0) begin
      n_err++;
      $display("FAIL valid_drop: O_Valid=%b want 0", O_Valid);
    end
  endtask

  task automatic test_reset_mid_block();
    send(attr(2, 5, 1, 1));
    send(32'h6666);
    send(32'h5001);
    send(32'h5002);
    I_Valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check_reset_values("midreset_vals");
    sbq.delete();
    m_st = 0; m_cnt = '0; m_mode = '0; m_flags = '0; m_shared = '0;
    reset = 1'b0;
    @(posedge clock); #1;
    check_reset_values("midreset_after");
    send(attr(1, 7, 0, 0));
    n_cmp++;
    if ({O_Kind, O_Remain, O_Mode, O_Shared} !== {2'd0, 8'd7, 2'd1, 32'h0}) begin
      n_err++;
      $display("FAIL midreset_attr: k=%0d r=%0d m=%0d s=%h want k=0 r=7 m=1 s=0", O_Kind, O_Remain, O_Mode, O_Shared);
    end
    for (int i = 0; i < 7; i++) send(32'h7000 + i);
    idle_drain();
  endtask

  task automatic test_max_len();
    send(attr(0, 255, 0, 1));
    n_cmp++;
    if (O_Remain !== 8'd255) begin
      n_err++;
      $display("FAIL maxlen_attr: r=%0d want 255", O_Remain);
    end
    for (int i = 0; i < 255; i++) send(32'h8000 + i);
    n_cmp++;
    if ({O_Remain, O_Last, O_Term} !== {8'd0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL maxlen_last: r=%0d l=%b t=%b want r=0 l=1 t=1", O_Remain, O_Last, O_Term);
    end
    idle_drain();
  endtask

  task automatic test_random();
    for (int b = 0; b < 8; b++) begin
      int len;
      bit sh;
      len = $urandom_range(0, 4);
      sh  = 1'($urandom_range(0, 1));
      send(attr($urandom_range(0, 3), len, sh, 1'($urandom_range(0, 1))) | 32'($urandom_range(0, 3)) << 5);
      if (sh) send($urandom);
      for (int i = 0; i < len; i++) send($urandom);
    end
    idle_drain();
  endtask

  initial begin
    test_reset();
    test_plain();
    test_shared();
    test_zero_len();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_block();
    test_max_len();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
